// File: rtl/seq_detect_1011_mux_sched.sv
// Time-multiplexed 1011 sequence detector: serves NUM_CH serial channels with one FSM datapath.
// A round-robin arbiter picks one channel per cycle and advances that channel's saved context.
module seq_detect_1011_mux_sched #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] in_valid,
    input  logic [NUM_CH-1:0] in_bit,
    output logic [NUM_CH-1:0] in_ready,
    input  logic [NUM_CH-1:0] ch_clear,
    output logic              match_valid,
    output logic [CH_W-1:0]   match_ch,
    input  logic [CH_W-1:0]   cnt_sel,
    output logic [CNT_W-1:0]  cnt_value
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    state_t           ctx [NUM_CH];
    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [CH_W-1:0]  rr_ptr;

    logic [NUM_CH-1:0] eligible;
    logic              grant_any;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   cand;
    state_t            next_state;

    function automatic state_t step(input state_t s, input logic x);
        case (s)
            IDLE:    return x ? S1    : IDLE;
            S1:      return x ? S1    : S10;
            S10:     return x ? S101  : IDLE;
            S101:    return x ? S1011 : S10;
            S1011:   return x ? S1    : S10;
            default: return IDLE;
        endcase
    endfunction

    assign eligible = in_valid & ~ch_clear;

    // Round-robin scan starting at rr_ptr; a channel being cleared is never granted.
    always_comb begin
        in_ready  = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!reset && enable) begin
            for (int off = 0; off < NUM_CH; off++) begin
                cand = CH_W'((int'(rr_ptr) + off) % NUM_CH);
                if (!grant_any && eligible[cand]) begin
                    grant_any       = 1'b1;
                    grant_idx       = cand;
                    in_ready[cand]  = 1'b1;
                end
            end
        end
    end

    assign next_state = step(ctx[grant_idx], in_bit[grant_idx]);
    assign cnt_value  = (int'(cnt_sel) < NUM_CH) ? cnt[cnt_sel] : '0;

    // Clears and the granted step never target the same channel, so their writes cannot collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx[i] <= IDLE;
                cnt[i] <= '0;
            end
            rr_ptr      <= '0;
            match_valid <= 1'b0;
            match_ch    <= '0;
        end else begin
            match_valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clear[i]) begin
                    ctx[i] <= IDLE;
                    cnt[i] <= '0;
                end
            end
            if (grant_any) begin
                ctx[grant_idx] <= next_state;
                rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
                if (next_state == S1011) begin
                    match_valid <= 1'b1;
                    match_ch    <= grant_idx;
                    if (!(&cnt[grant_idx]))
                        cnt[grant_idx] <= cnt[grant_idx] + 1'b1;
                end
            end
        end
    end

endmodule
